// File: rtl/ctrl_pkg.sv
// Shared constants and fault-cause encoding for the step/direction readback path.
package ctrl_pkg;

    localparam int AXES  = 6;
    localparam int POS_W = 12;

    typedef enum logic [1:0] {
        FC_NONE  = 2'b00,
        FC_UNPWR = 2'b01,
        FC_SETUP = 2'b10,
        FC_OVR   = 2'b11
    } fault_cause_t;

    // Resolve simultaneous faults on one axis: unpowered > DR setup > overrange.
    function automatic fault_cause_t cause_pick(input logic unpwr,
                                                input logic setup,
                                                input logic ovr);
        if (unpwr) return FC_UNPWR;
        if (setup) return FC_SETUP;
        if (ovr)   return FC_OVR;
        return FC_NONE;
    endfunction

endpackage

// File: rtl/step_axis.sv
// One stepper channel: PU edge detect, Stop synchronizer, saturating position,
// DR stability counter, idle counter and first-cause fault latch.
module step_axis #(
    parameter int POS_W    = 12,
    parameter int DR_SETUP = 2,
    parameter int IDLE_CYC = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_pu,
    input  logic                    i_dr,
    input  logic                    i_mf,
    input  logic                    i_stop,
    input  logic                    i_clear,
    output logic signed [POS_W-1:0] o_pos,
    output logic [1:0]              o_cause,
    output logic                    o_homed,
    output logic                    o_fault,
    output logic                    o_moving
);
    import ctrl_pkg::*;

    localparam int DW = $clog2(DR_SETUP + 1);
    localparam int IW = $clog2(IDLE_CYC + 1);
    localparam logic [DW-1:0]           DR_MAX  = DW'(DR_SETUP);
    localparam logic [IW-1:0]           IDLE_LD = IW'(IDLE_CYC);
    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    logic                    r_pu1, r_pu2, r_dr1, r_mf1;
    logic                    r_stop1, r_stop2;
    logic [DW-1:0]           r_dr_cnt;
    logic [IW-1:0]           r_idle;
    logic signed [POS_W-1:0] r_pos;
    logic                    r_homed;
    fault_cause_t            r_cause;

    logic                    w_step, w_home, w_act, w_setup, w_ovr;
    fault_cause_t            w_new_cause;

    // Input staging; PU history resets high so a PU held across reset is not a new edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pu1 <= 1'b1;
            r_pu2 <= 1'b1;
            r_dr1 <= 1'b0;
            r_mf1 <= 1'b0;
        end else begin
            r_pu1 <= i_pu;
            r_pu2 <= r_pu1;
            r_dr1 <= i_dr;
            r_mf1 <= i_mf;
        end
    end

    // Two-flop synchronizer for the asynchronous limit sensor.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stop1 <= 1'b0;
            r_stop2 <= 1'b0;
        end else begin
            r_stop1 <= i_stop;
            r_stop2 <= r_stop1;
        end
    end

    // Step qualification and fault classification for this cycle.
    always_comb begin
        w_step      = r_pu1 & ~r_pu2;
        w_home      = r_stop2;
        w_act       = w_step & ~w_home;
        w_setup     = (r_dr_cnt < DR_MAX);
        w_ovr       = r_dr1 ? (r_pos == POS_MAX) : (r_pos == POS_MIN);
        w_new_cause = FC_NONE;
        if (w_act) begin
            w_new_cause = cause_pick(~r_mf1, w_setup, w_ovr);
        end
    end

    // DR stability counter: restarts whenever the staged direction changes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dr_cnt <= '0;
        end else if (i_dr != r_dr1) begin
            r_dr_cnt <= '0;
        end else if (r_dr_cnt < DR_MAX) begin
            r_dr_cnt <= r_dr_cnt + DW'(1);
        end
    end

    // Position counter: homing overrides steps; unpowered or overrange steps do not move.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pos   <= '0;
            r_homed <= 1'b0;
        end else if (w_home) begin
            r_pos   <= '0;
            r_homed <= 1'b1;
        end else if (w_act && r_mf1 && !w_ovr) begin
            r_pos <= r_dr1 ? (r_pos + POS_ONE) : (r_pos - POS_ONE);
        end
    end

    // First fault cause latches; a fault coincident with Clear is kept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cause <= FC_NONE;
        end else if ((w_new_cause != FC_NONE) && ((r_cause == FC_NONE) || i_clear)) begin
            r_cause <= w_new_cause;
        end else if (i_clear) begin
            r_cause <= FC_NONE;
        end
    end

    // Idle counter: reloaded on every accepted step, drains to zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idle <= '0;
        end else if (w_act) begin
            r_idle <= IDLE_LD;
        end else if (r_idle != '0) begin
            r_idle <= r_idle - IW'(1);
        end
    end

    assign o_pos    = r_pos;
    assign o_cause  = r_cause;
    assign o_homed  = r_homed;
    assign o_fault  = (r_cause != FC_NONE);
    assign o_moving = (r_idle != '0);

endmodule

// File: rtl/step_monitor.sv
// Step/direction receiver: AXES channel decoders plus registered Sel readback.
module step_monitor #(
    parameter int AXES     = ctrl_pkg::AXES,
    parameter int POS_W    = ctrl_pkg::POS_W,
    parameter int DR_SETUP = 2,
    parameter int IDLE_CYC = 1000
) (
    input  logic                    sysclk,
    input  logic                    Reset,
    input  logic [AXES-1:0]         PU,
    input  logic [AXES-1:0]         DR,
    input  logic [AXES-1:0]         MF,
    input  logic [AXES-1:0]         Stop,
    input  logic                    Clear,
    input  logic [2:0]              Sel,
    output logic signed [POS_W-1:0] PosOut,
    output logic [1:0]              CauseOut,
    output logic [AXES-1:0]         Homed,
    output logic [AXES-1:0]         Fault,
    output logic [AXES-1:0]         Moving
);
    import ctrl_pkg::*;

    logic signed [POS_W-1:0] w_pos   [AXES];
    logic [1:0]              w_cause [AXES];

    for (genvar g = 0; g < AXES; g++) begin : g_axis
        step_axis #(
            .POS_W    (POS_W),
            .DR_SETUP (DR_SETUP),
            .IDLE_CYC (IDLE_CYC)
        ) u_axis (
            .i_clk    (sysclk),
            .i_rst    (Reset),
            .i_pu     (PU[g]),
            .i_dr     (DR[g]),
            .i_mf     (MF[g]),
            .i_stop   (Stop[g]),
            .i_clear  (Clear),
            .o_pos    (w_pos[g]),
            .o_cause  (w_cause[g]),
            .o_homed  (Homed[g]),
            .o_fault  (Fault[g]),
            .o_moving (Moving[g])
        );
    end

    // Registered readback of the selected axis; unused select codes read as zero.
    always_ff @(posedge sysclk or posedge Reset) begin
        if (Reset) begin
            PosOut   <= '0;
            CauseOut <= FC_NONE;
        end else if (int'(Sel) < AXES) begin
            PosOut   <= w_pos[Sel];
            CauseOut <= w_cause[Sel];
        end else begin
            PosOut   <= '0;
            CauseOut <= FC_NONE;
        end
    end

endmodule
